// File: rtl/vs_residual_updater_pkg.sv
// Shared fixed-point types and helpers for the vector-search datapath.
// fp_32_t is a signed Q-format word; saturation clamps to the representable range.
package vs_residual_updater_pkg;

    localparam int unsigned FP_DATA_BUS_WIDTH = 32;

    typedef logic signed [FP_DATA_BUS_WIDTH-1:0] fp_32_t;

    localparam fp_32_t FP_MAX = 32'sh7FFF_FFFF;
    localparam fp_32_t FP_MIN = 32'sh8000_0000;

    function automatic fp_32_t vs_fp_sat32(input logic signed [63:0] x);
        if (x > 64'sh0000_0000_7FFF_FFFF) begin
            return FP_MAX;
        end
        if (x < -64'sh0000_0000_8000_0000) begin
            return FP_MIN;
        end
        return x[31:0];
    endfunction

endpackage

// File: rtl/vs_fp_mul_reg.sv
// Registered Q-format multiply: p = sat32((a*b) >>> Q), one cycle of latency.
// The arithmetic shift rounds toward -inf, so small negative products give -1, not 0.
module vs_fp_mul_reg
    import vs_residual_updater_pkg::*;
#(
    parameter int unsigned Q = 15
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   valid_i,
    input  fp_32_t a_i,
    input  fp_32_t b_i,
    output logic   valid_o,
    output fp_32_t p_o
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod;
    logic signed [63:0] prod_sh;
    logic               valid_q;
    fp_32_t             p_q;

    assign a_ext   = 64'(a_i);
    assign b_ext   = 64'(b_i);
    assign prod    = a_ext * b_ext;
    assign prod_sh = prod >>> Q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            p_q     <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                p_q <= vs_fp_sat32(prod_sh);
            end
        end
    end

    assign valid_o = valid_q;
    assign p_o     = p_q;

endmodule

// File: rtl/vs_residual_updater.sv
// Matching-pursuit residual update: r[i] <- sat32(r[i] - coef*phi[i][k]) in place,
// accumulating the squared norm of the new residual for the stopping test.
module vs_residual_updater
    import vs_residual_updater_pkg::*;
#(
    parameter int unsigned ROWS       = 64,
    parameter int unsigned COLUMNS    = 256,
    parameter int unsigned Q          = 15,
    parameter int unsigned PHI_ADDR_W = 14
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            atom_index,
    input  logic [31:0]           coef,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [PHI_ADDR_W-1:0] phi_read_addr,
    input  logic [31:0]           phi_read_data,
    output logic [7:0]            res_read_addr,
    input  logic [31:0]           res_read_data,
    output logic                  res_write_enable,
    output logic [7:0]            res_write_addr,
    output logic [31:0]           res_write_data,
    output logic [31:0]           energy
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

    state_t                  state_q;
    logic [7:0]              row_q;
    logic [PHI_ADDR_W-1:0]   phi_addr_q;
    logic                    rd_valid_q;
    logic                    dat_valid_q;
    logic [7:0]              dat_addr_q;
    logic [7:0]              wr_addr_q;
    fp_32_t                  coef_q;
    fp_32_t                  r_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic [63:0]             acc_q;
    fp_32_t                  energy_q;

    logic                    p_valid;
    fp_32_t                  p;
    logic signed [63:0]      diff;
    fp_32_t                  wr_data_d;
    logic signed [63:0]      sq;
    logic signed [63:0]      sq_sh;
    logic [63:0]             acc_d;

    // Stage 1: product of coef and phi, aligned with the registered residual word.
    vs_fp_mul_reg #(
        .Q(Q)
    ) u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .valid_i (dat_valid_q),
        .a_i     (coef_q),
        .b_i     (fp_32_t'(phi_read_data)),
        .valid_o (p_valid),
        .p_o     (p)
    );

    // Stage 2: subtract and square; the write strobe follows the multiplier valid.
    always_comb begin
        diff      = 64'(r_q) - 64'(p);
        wr_data_d = vs_fp_sat32(diff);
        sq        = 64'(wr_data_d) * 64'(wr_data_d);
        sq_sh     = sq >>> Q;
        acc_d     = acc_q;
        if (p_valid) begin
            acc_d = acc_q + 64'(sq_sh);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            phi_addr_q  <= '0;
            rd_valid_q  <= 1'b0;
            dat_valid_q <= 1'b0;
            dat_addr_q  <= '0;
            wr_addr_q   <= '0;
            coef_q      <= '0;
            r_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            acc_q       <= '0;
            energy_q    <= '0;
        end else begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            dat_valid_q <= rd_valid_q;
            dat_addr_q  <= row_q;
            if (dat_valid_q) begin
                r_q       <= fp_32_t'(res_read_data);
                wr_addr_q <= dat_addr_q;
            end
            if (p_valid) begin
                acc_q <= acc_d;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (32'(atom_index) < COLUMNS) begin
                            coef_q     <= fp_32_t'(coef);
                            phi_addr_q <= PHI_ADDR_W'(32'(atom_index) * ROWS);
                            row_q      <= '0;
                            rd_valid_q <= 1'b1;
                            acc_q      <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= STREAM;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (row_q == LAST_ROW) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= DRAIN;
                    end else begin
                        row_q      <= row_q + 8'd1;
                        phi_addr_q <= phi_addr_q + PHI_ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Energy is committed on the edge that retires the last write.
                    if (p_valid && wr_addr_q == LAST_ROW) begin
                        energy_q <= (acc_d > 64'h0000_0000_7FFF_FFFF) ? FP_MAX
                                                                      : fp_32_t'(acc_d[31:0]);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign phi_read_addr    = phi_addr_q;
    assign res_read_addr    = row_q;
    assign res_write_enable = p_valid;
    assign res_write_addr   = wr_addr_q;
    assign res_write_data   = wr_data_d;
    assign energy           = energy_q;

endmodule

// File: tb/tb_vs_residual_updater.sv
// Bench for vs_residual_updater: dual-port memory model, directed corner cases and
// randomized updates checked against an arithmetic reference of the update rule.
module tb_vs_residual_updater;

    localparam int ROWS       = 4;
    localparam int COLUMNS    = 16;
    localparam int Q          = 15;
    localparam int PHI_ADDR_W = 6;
    localparam int PHI_WORDS  = ROWS * COLUMNS;

    logic                  clock;
    logic                  reset_n;
    logic                  start;
    logic [7:0]            atom_index;
    logic [31:0]           coef;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [PHI_ADDR_W-1:0] phi_read_addr;
    logic [31:0]           phi_read_data;
    logic [7:0]            res_read_addr;
    logic [31:0]           res_read_data;
    logic                  res_write_enable;
    logic [7:0]            res_write_addr;
    logic [31:0]           res_write_data;
    logic [31:0]           energy;

    int  res_mem [ROWS];
    int  phi_mem [PHI_WORDS];
    logic        ld_en;
    int          ld_addr;
    int          ld_data;
    int          cyc;
    int          wr_count;
    int          last_wr_cyc;
    int          done_count;
    int          err_count;
    int          n_tests;
    int          n_fail;
    longint      last_exp_e;

    vs_residual_updater #(
        .ROWS       (ROWS),
        .COLUMNS    (COLUMNS),
        .Q          (Q),
        .PHI_ADDR_W (PHI_ADDR_W)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .atom_index       (atom_index),
        .coef             (coef),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .phi_read_addr    (phi_read_addr),
        .phi_read_data    (phi_read_data),
        .res_read_addr    (res_read_addr),
        .res_read_data    (res_read_data),
        .res_write_enable (res_write_enable),
        .res_write_addr   (res_write_addr),
        .res_write_data   (res_write_data),
        .energy           (energy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memories with one-cycle read latency, plus event counters.
    always @(posedge clock) begin
        cyc           <= cyc + 1;
        res_read_data <= res_mem[int'(res_read_addr) % ROWS];
        phi_read_data <= phi_mem[phi_read_addr];
        if (ld_en) res_mem[ld_addr] <= ld_data;
        if (res_write_enable) begin
            res_mem[int'(res_write_addr) % ROWS] <= res_write_data;
            wr_count    <= wr_count + 1;
            last_wr_cyc <= cyc;
        end
        if (done)  done_count <= done_count + 1;
        if (error) err_count  <= err_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic longint sat(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom);
            1:       return int'($urandom_range(0, 131071)) - 65536;
            2:       return ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return int'($urandom_range(0, 8191)) - 4096;
        endcase
    endfunction

    task automatic load_res(input int v [ROWS]);
        for (int i = 0; i < ROWS; i++) begin
            @(negedge clock);
            ld_en = 1'b1; ld_addr = i; ld_data = v[i];
        end
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    task automatic fill_phi(input int atom, input int v);
        for (int i = 0; i < ROWS; i++) phi_mem[atom * ROWS + i] = v;
    endtask

    task automatic run_op(input int atom, input int c, input bit glitch);
        longint          exp_r [ROWS];
        longint unsigned acc;
        longint          p;
        longint          w;
        int              s;
        int              wr0;
        int              dn0;
        int              er0;
        bit              seen;
        acc = 0;
        for (int i = 0; i < ROWS; i++) begin
            p        = sat((longint'(c) * longint'(phi_mem[atom * ROWS + i])) >>> Q);
            w        = sat(longint'(res_mem[i]) - p);
            exp_r[i] = w;
            acc      = acc + longint'(unsigned'((w * w) >>> Q));
        end
        last_exp_e = (acc > 64'd2147483647) ? 64'd2147483647 : longint'(acc);
        wr0 = wr_count; dn0 = done_count; er0 = err_count;
        @(negedge clock);
        start = 1'b1; atom_index = 8'(atom); coef = c; s = cyc;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int i = 0; i < ROWS; i++) begin
            check("phi_addr", phi_read_addr, 64'(atom * ROWS + i));
            check("res_addr", res_read_addr, 64'(i));
            start = (glitch && i == 1);
            atom_index = glitch ? 8'd0 : 8'(atom);
            @(negedge clock);
        end
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            if (done) seen = 1'b1;
            else @(negedge clock);
        end
        check("done_seen", seen, 1);
        check("done_latency", 64'(cyc - s), 64'(ROWS + 3));
        check("busy_at_done", busy, 0);
        check("energy", energy, 64'(last_exp_e));
        check("write_count", 64'(wr_count - wr0), 64'(ROWS));
        check("last_write_cycle", 64'(last_wr_cyc - s), 64'(ROWS + 2));
        for (int i = 0; i < ROWS; i++) check("residual", 64'(res_mem[i]), 64'(exp_r[i]));
        repeat (3) @(negedge clock);
        check("done_pulses", 64'(done_count - dn0), 1);
        check("no_error", 64'(err_count - er0), 0);
    endtask

    initial begin
        int v [ROWS];
        int s;
        int wr0;
        int dn0;
        int er0;
        n_tests = 0; n_fail = 0;
        cyc = 0; wr_count = 0; last_wr_cyc = 0; done_count = 0; err_count = 0;
        ld_en = 1'b0; ld_addr = 0; ld_data = 0;
        start = 1'b0; atom_index = '0; coef = '0;
        for (int i = 0; i < PHI_WORDS; i++) phi_mem[i] = 0;
        for (int i = 0; i < ROWS; i++) res_mem[i] = 0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_wen", res_write_enable, 0);
        check("rst_energy", energy, 0);
        reset_n = 1'b1;

        // Basic update on atom 3.
        v = '{32768, 16384, 0, -32768};
        fill_phi(3, 16384);
        load_res(v);
        run_op(3, 32768, 1'b0);
        check("t1_energy_const", energy, 64'd90112);
        check("t1_r3_const", 64'(res_mem[3]), 64'(-49152));

        // Zero coefficient, with an ignored start while busy.
        load_res(v);
        run_op(3, 0, 1'b1);
        check("t2_energy_const", energy, 64'd73728);

        // Positive saturation of the written word and of energy.
        v = '{32'h7FFF_FFFF, 0, 0, 0};
        fill_phi(5, -65536);
        load_res(v);
        run_op(5, 32768, 1'b0);
        check("t3_sat_word", 64'(res_mem[0]), 64'h7FFF_FFFF);
        check("t3_sat_energy", energy, 64'h7FFF_FFFF);

        // Out-of-range atom is rejected with a single error pulse.
        wr0 = wr_count; er0 = err_count;
        @(negedge clock);
        start = 1'b1; atom_index = 8'(COLUMNS); coef = 32768; s = cyc;
        @(negedge clock);
        start = 1'b0;
        check("err_pulse", error, 1);
        check("err_busy", busy, 0);
        @(negedge clock);
        check("err_pulse_end", error, 0);
        repeat (ROWS + 4) @(negedge clock);
        check("err_no_writes", 64'(wr_count - wr0), 0);
        check("err_count", 64'(err_count - er0), 1);
        check("err_energy_kept", energy, 64'(last_exp_e));

        // Reset in the middle of an update aborts it.
        v = '{1000, 2000, 3000, 4000};
        fill_phi(2, 32768);
        load_res(v);
        dn0 = done_count;
        @(negedge clock);
        start = 1'b1; atom_index = 8'd2; coef = 32768; s = cyc;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_mid_cycle", 64'(cyc - s), 4);
        reset_n = 1'b0;
        @(negedge clock);
        check("rst_mid_wen", res_write_enable, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_energy", energy, 0);
        wr0 = wr_count;
        reset_n = 1'b1;
        repeat (ROWS + 6) @(negedge clock);
        check("rst_mid_no_done", 64'(done_count - dn0), 0);
        check("rst_mid_no_writes", 64'(wr_count - wr0), 0);
        run_op(2, 32768, 1'b0);

        // Negative product rounds toward -inf; highest valid atom.
        v = '{0, 0, 0, 0};
        fill_phi(COLUMNS - 1, -1);
        load_res(v);
        run_op(COLUMNS - 1, 1, 1'b0);
        check("t6_trunc", 64'(res_mem[0]), 1);

        // Randomized updates.
        for (int it = 0; it < 12; it++) begin
            int atom;
            atom = int'($urandom_range(0, COLUMNS - 1));
            for (int i = 0; i < ROWS; i++) begin
                v[i] = rnd_val();
                phi_mem[atom * ROWS + i] = rnd_val();
            end
            load_res(v);
            run_op(atom, rnd_val(), it[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
